multi_start_gen: RTL and testbench

Parametrised successor to the two-input start pulser: collects N ready lines from upstream data producers and issues a single-cycle start to the processing core. It then tracks the operation through busy/done, and re-arms only after an explicit clear. Adds per-channel masking, ALL/ANY mode, optional sticky capture of ready pulses, and an operation timeout.

---
 rtl/multi_start_gen_pkg.sv | 37 +++
 rtl/multi_start_gen_if.sv | 29 ++
 rtl/multi_start_gen_ready_latch.sv | 39 +++
 rtl/multi_start_gen.sv | 134 +++++++++++++
 tb/tb_multi_start_gen.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/multi_start_gen_pkg.sv
// Shared types and constants for the multi-channel start generator.
// Provides the FSM state encoding, the ALL/ANY mode encodings and the
// launch-condition helper used by the top level.
package multi_start_gen_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic MODE_ALL = 1'b0;
    localparam logic MODE_ANY = 1'b1;

    // Widest supported channel count; the helper works at this width.
    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } start_state_t;

    // ALL: every enabled channel ready, and at least one channel enabled.
    // ANY: at least one enabled channel ready.
    // Unused upper bits come in as zero on both eff and mask. Their
    // ~mask bits are then 1, so they never block the ALL reduction.
    function automatic logic launch_cond(input logic [MAX_CH-1:0] eff,
                                         input logic [MAX_CH-1:0] mask,
                                         input logic              mode);
        logic c;
        case (mode)
            MODE_ALL: c = (&(eff | ~mask)) & (|mask);
            MODE_ANY: c = |eff;
            default:  c = FALSE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_start_gen_if.sv
// Handshake bundle between upstream producers / control and the start generator.
// master: drives ready/mask/mode/done/clr/to_limit and observes the launch outputs.
// slave : the start generator itself.
interface multi_start_gen_if #(
    parameter int N_CH = 2,
    parameter int TO_W = 8
);
    logic [N_CH-1:0] ready;
    logic [N_CH-1:0] mask;
    logic            mode;
    logic            done;
    logic            clr;
    logic [TO_W-1:0] to_limit;
    logic            start;
    logic            busy;
    logic [N_CH-1:0] launch_src;
    logic            err_to;
    logic            armed;

    modport master (
        output ready, mask, mode, done, clr, to_limit,
        input  start, busy, launch_src, err_to, armed
    );

    modport slave (
        input  ready, mask, mode, done, clr, to_limit,
        output start, busy, launch_src, err_to, armed
    );
endinterface

// File: rtl/multi_start_gen_ready_latch.sv
// Per-channel ready capture.
// STICKY != 0: a ready pulse seen while set_en is high is held until clear.
// STICKY == 0: no storage. The channel follows the live ready level.
// Ports: clk, rst (async high), ready, mask, set_en (block is idle),
//        clear (launch or clr), eff (masked effective ready).
module multi_start_gen_ready_latch #(
    parameter int STICKY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ready,
    input  logic mask,
    input  logic set_en,
    input  logic clear,
    output logic eff
);

    generate
        if (STICKY != 0) begin : g_sticky
            logic lat;

            // Clear has priority: a ready arriving on the launch cycle is
            // consumed by that launch, not carried into the next one.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    lat <= 1'b0;
                else if (clear)
                    lat <= 1'b0;
                else if (set_en && ready)
                    lat <= 1'b1;
            end

            assign eff = mask & (lat | ready);
        end else begin : g_level
            assign eff = mask & ready;
        end
    endgenerate

endmodule

// File: rtl/multi_start_gen.sv
// Multi-channel start generator.
// Collects N_CH ready lines. When the ALL/ANY condition over the enabled
// channels holds in IDLE, it issues a one-cycle start. It then tracks the
// operation through done or timeout, and re-arms only after clr.
// Ports: clk, rst (async high), bus (slave modport):
//   in : ready, mask, mode, done, clr, to_limit
//   out: start, busy, launch_src, err_to, armed
module multi_start_gen
    import multi_start_gen_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int TO_W   = 8,
    parameter int STICKY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_start_gen_if.slave     bus
);

    start_state_t    state, state_n;
    logic            start_q, start_n;
    logic            busy_q, busy_n;
    logic            err_q, err_n;
    logic [N_CH-1:0] src_q, src_n;
    logic [TO_W-1:0] cnt, cnt_n;
    logic            clr_pend, clr_pend_n;
    logic [N_CH-1:0] eff;
    logic            cond;
    logic            launch;
    logic            in_idle;
    logic            to_hit;

    assign in_idle = (state == ST_IDLE);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        multi_start_gen_ready_latch #(.STICKY(STICKY)) u_lat (
            .clk    (clk),
            .rst    (rst),
            .ready  (bus.ready[i]),
            .mask   (bus.mask[i]),
            .set_en (in_idle),
            .clear  (launch | bus.clr),
            .eff    (eff[i])
        );
    end

    assign cond = launch_cond(MAX_CH'(eff), MAX_CH'(bus.mask), bus.mode);

    // The counter starts at 0 on the first RUN cycle. Matching limit-1
    // therefore fires on the to_limit-th RUN cycle.
    assign to_hit = (bus.to_limit != '0) && (cnt == bus.to_limit - TO_W'(1));

    always_comb begin
        state_n    = state;
        start_n    = FALSE;
        busy_n     = busy_q;
        err_n      = FALSE;
        src_n      = src_q;
        cnt_n      = cnt;
        clr_pend_n = clr_pend;
        launch     = FALSE;

        case (state)
            ST_IDLE: begin
                if (cond) begin
                    launch     = TRUE;
                    start_n    = TRUE;
                    busy_n     = TRUE;
                    src_n      = eff;
                    cnt_n      = '0;
                    clr_pend_n = FALSE;
                    state_n    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt != '1)
                    cnt_n = cnt + TO_W'(1);
                if (bus.done) begin
                    // done wins over timeout. A clr in the same cycle
                    // skips HOLD entirely.
                    busy_n = FALSE;
                    if (bus.clr) begin
                        clr_pend_n = FALSE;
                        state_n    = ST_IDLE;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end else if (to_hit) begin
                    err_n      = TRUE;
                    busy_n     = FALSE;
                    clr_pend_n = clr_pend | bus.clr;
                    state_n    = ST_HOLD;
                end else begin
                    clr_pend_n = clr_pend | bus.clr;
                end
            end
            ST_HOLD: begin
                // A clr recorded during RUN releases HOLD after one cycle.
                if (bus.clr || clr_pend) begin
                    clr_pend_n = FALSE;
                    state_n    = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            src_q    <= '0;
            cnt      <= '0;
            clr_pend <= 1'b0;
        end else begin
            state    <= state_n;
            start_q  <= start_n;
            busy_q   <= busy_n;
            err_q    <= err_n;
            src_q    <= src_n;
            cnt      <= cnt_n;
            clr_pend <= clr_pend_n;
        end
    end

    assign bus.start      = start_q;
    assign bus.busy       = busy_q;
    assign bus.err_to     = err_q;
    assign bus.launch_src = src_q;
    assign bus.armed      = in_idle;

endmodule

// File: tb/tb_multi_start_gen.sv
// Directed bench for multi_start_gen (N_CH=2, TO_W=8, STICKY=1).
module tb_multi_start_gen;
    import multi_start_gen_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;

    multi_start_gen_if #(.N_CH(2), .TO_W(8)) bus ();

    multi_start_gen #(.N_CH(2), .TO_W(8), .STICKY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Step one clock edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ready = 2'b00; bus.mask = 2'b11; bus.mode = MODE_ALL;
        bus.done = 1'b0;   bus.clr = 1'b0;   bus.to_limit = 8'd0;

        // reset
        repeat (3) tick();
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_err",   32'(bus.err_to), 0);
        chk("rst_src",   32'(bus.launch_src), 0);
        rst = 1'b0;
        tick();
        chk("rst_armed", 32'(bus.armed), 1);

        // ALL mode, level ready: 01 then 11
        bus.ready = 2'b01; tick();
        chk("all_partial", 32'(bus.start), 0);
        bus.ready = 2'b11; tick();
        chk("all_start", 32'(bus.start), 1);
        chk("all_src",   32'(bus.launch_src), 3);
        chk("all_busy",  32'(bus.busy), 1);
        chk("all_armed", 32'(bus.armed), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("run_nostart", 32'(bus.start), 0);
        end
        chk("run_busy", 32'(bus.busy), 1);
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        chk("done_busy",  32'(bus.busy), 0);
        chk("done_hold",  32'(bus.armed), 0);
        chk("done_noerr", 32'(bus.err_to), 0);
        repeat (3) tick();
        chk("hold_nostart", 32'(bus.start), 0);
        chk("hold_stays",   32'(bus.armed), 0);
        bus.ready = 2'b00;
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        chk("clr_armed", 32'(bus.armed), 1);
        tick();
        chk("hold_ready_not_latched", 32'(bus.start), 0);

        // sticky capture of separate pulses
        bus.ready = 2'b01; tick(); bus.ready = 2'b00;
        chk("sticky_first", 32'(bus.start), 0);
        repeat (4) tick();
        chk("sticky_gap", 32'(bus.start), 0);
        chk("sticky_gap_armed", 32'(bus.armed), 1);
        bus.ready = 2'b10; tick(); bus.ready = 2'b00;
        chk("sticky_start", 32'(bus.start), 1);
        chk("sticky_src",   32'(bus.launch_src), 3);
        tick();
        chk("sticky_single", 32'(bus.start), 0);
        bus.done = 1'b1; bus.clr = 1'b1; tick(); bus.done = 1'b0; bus.clr = 1'b0;
        chk("done_clr_idle", 32'(bus.armed), 1);
        tick();
        chk("sticky_cleared", 32'(bus.start), 0);

        // ANY mode with mask=10
        bus.mode = MODE_ANY; bus.mask = 2'b10; bus.ready = 2'b01;
        repeat (2) tick();
        chk("any_masked", 32'(bus.start), 0);
        bus.ready = 2'b10; tick(); bus.ready = 2'b00;
        chk("any_start", 32'(bus.start), 1);
        chk("any_src",   32'(bus.launch_src), 2);
        bus.done = 1'b1; bus.clr = 1'b1; tick(); bus.done = 1'b0; bus.clr = 1'b0;
        chk("any_idle", 32'(bus.armed), 1);
        chk("any_busy", 32'(bus.busy), 0);
        tick();
        chk("any_norelaunch", 32'(bus.start), 0);

        // timeout, to_limit=5
        bus.mode = MODE_ALL; bus.mask = 2'b11; bus.to_limit = 8'd5;
        bus.ready = 2'b11; tick(); bus.ready = 2'b00;
        chk("to_start", 32'(bus.start), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_early", 32'(bus.err_to), 0);
        end
        tick();
        chk("to_err",   32'(bus.err_to), 1);
        chk("to_busy",  32'(bus.busy), 0);
        chk("to_hold",  32'(bus.armed), 0);
        tick();
        chk("to_pulse", 32'(bus.err_to), 0);
        chk("to_hold2", 32'(bus.armed), 0);
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        chk("to_clr", 32'(bus.armed), 1);

        // done coincides with the timeout cycle
        bus.ready = 2'b11; tick(); bus.ready = 2'b00;
        chk("tod_start", 32'(bus.start), 1);
        repeat (4) tick();
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        chk("tod_noerr", 32'(bus.err_to), 0);
        chk("tod_busy",  32'(bus.busy), 0);
        chk("tod_hold",  32'(bus.armed), 0);
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        bus.to_limit = 8'd0;

        // clr during RUN, later done
        bus.ready = 2'b11; tick(); bus.ready = 2'b00;
        chk("cr_start", 32'(bus.start), 1);
        tick();
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        tick();
        chk("cr_still_run", 32'(bus.armed), 0);
        chk("cr_busy",      32'(bus.busy), 1);
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        chk("cr_hold", 32'(bus.armed), 0);
        chk("cr_notbusy", 32'(bus.busy), 0);
        tick();
        chk("cr_idle", 32'(bus.armed), 1);
        bus.ready = 2'b11; tick(); bus.ready = 2'b00;
        chk("cr_second_start", 32'(bus.start), 1);
        bus.done = 1'b1; bus.clr = 1'b1; tick(); bus.done = 1'b0; bus.clr = 1'b0;

        // async reset mid-RUN
        bus.ready = 2'b11; tick(); bus.ready = 2'b00;
        chk("ar_start", 32'(bus.start), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_start0", 32'(bus.start), 0);
        chk("ar_busy0",  32'(bus.busy), 0);
        chk("ar_err0",   32'(bus.err_to), 0);
        chk("ar_src0",   32'(bus.launch_src), 0);
        #1 rst = 1'b0;
        tick();
        chk("ar_armed", 32'(bus.armed), 1);

        // mask=00 never launches
        bus.mask = 2'b00; bus.ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mask0_all", 32'(bus.start), 0);
        end
        bus.mode = MODE_ANY;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mask0_any", 32'(bus.start), 0);
        end
        chk("mask0_armed", 32'(bus.armed), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
